// File: rtl/dac_pkg.sv
// Shared constants and types for the unit-element DAC driver path.
package dac_pkg;

    localparam int NELEM  = 32;
    localparam int CODE_W = 5;
    localparam int PTR_W  = 5;
    localparam logic [CODE_W-1:0] CODE_OFFSET = 5'd16;

    typedef logic [NELEM-1:0] sel_mask_t;

endpackage

// File: rtl/dwa_therm.sv
// Combinational 5-bit level count to 32-bit thermometer mask (bits 0..count-1 set).
module dwa_therm
    import dac_pkg::*;
(
    input  logic [PTR_W-1:0] count,
    output sel_mask_t        mask
);

    localparam sel_mask_t ALL_ONES = 32'hFFFF_FFFF;

    assign mask = ~(ALL_ONES << count);

endmodule

// File: rtl/dwa_shaper.sv
// Data-weighted-averaging mismatch shaper for a 32-element unit DAC.
// Optional macro DWA_BYPASS_EN adds a Bypass input selecting static thermometer mode.
module dwa_shaper
    import dac_pkg::*;
#(
    parameter logic [PTR_W-1:0] PTR_INIT = 5'd0
) (
    input  logic              clock,
    input  logic              rst,
`ifdef DWA_BYPASS_EN
    input  logic              Bypass,
`endif
    input  logic [CODE_W-1:0] DataIn,
    input  logic              DataValid,
    output sel_mask_t         SelOut,
    output logic              SelValid,
    output logic [PTR_W-1:0]  PtrOut
);

    logic [PTR_W-1:0] count_s;
    sel_mask_t        therm_s;
    sel_mask_t        rot_s;
    sel_mask_t        sel_nxt_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic             valid_nxt_s;

    sel_mask_t        sel_r;
    logic [PTR_W-1:0] ptr_r;
    logic             valid_r;

    // Offset-binary view of the signed code: -16..+15 maps onto 0..31 with natural wrap.
    assign count_s = DataIn + CODE_OFFSET;

    dwa_therm u_therm (
        .count (count_s),
        .mask  (therm_s)
    );

    assign rot_s = (therm_s << ptr_r) | (therm_s >> (6'd32 - {1'b0, ptr_r}));

    // Next select mask, pointer and valid flag for the coming edge.
    always_comb begin
        sel_nxt_s   = sel_r;
        ptr_nxt_s   = ptr_r;
        valid_nxt_s = 1'b0;
        if (DataValid) begin
            valid_nxt_s = 1'b1;
`ifdef DWA_BYPASS_EN
            if (Bypass) begin
                sel_nxt_s = therm_s;
                ptr_nxt_s = ptr_r;
            end else begin
                sel_nxt_s = rot_s;
                ptr_nxt_s = ptr_r + count_s;
            end
`else
            sel_nxt_s = rot_s;
            ptr_nxt_s = ptr_r + count_s;
`endif
        end else begin
            sel_nxt_s   = sel_r;
            ptr_nxt_s   = ptr_r;
            valid_nxt_s = 1'b0;
        end
    end

    // Output and pointer registers; reset discards any sample on the same edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            sel_r   <= 32'h0000_0000;
            ptr_r   <= PTR_INIT;
            valid_r <= 1'b0;
        end else begin
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign SelOut   = sel_r;
    assign SelValid = valid_r;
    assign PtrOut   = ptr_r;

endmodule
